// File: rtl/i2c_line_conditioner_if.sv
// rtl/i2c_line_conditioner_if.sv - pad-side and conditioned-side signals of the I2C line conditioner
interface i2c_line_conditioner_if;
  logic SDA_in;
  logic SCL_in;
  logic SDA_sync;
  logic SCL_sync;
  logic SCL_rise;
  logic SCL_fall;
  logic start_found;
  logic stop_found;
  logic bus_busy;
  logic bus_timeout;

  modport slave (
    input  SDA_in, SCL_in,
    output SDA_sync, SCL_sync, SCL_rise, SCL_fall,
           start_found, stop_found, bus_busy, bus_timeout
  );

  modport master (
    output SDA_in, SCL_in,
    input  SDA_sync, SCL_sync, SCL_rise, SCL_fall,
           start_found, stop_found, bus_busy, bus_timeout
  );
endinterface

// File: rtl/i2c_line_conditioner.sv
// rtl/i2c_line_conditioner.sv - SDA/SCL synchroniser, glitch filter, edge/START/STOP detect, bus-busy tracking
// Optional SCL-stuck-low timeout is built only when I2C_BUS_TIMEOUT_EN is defined.
module i2c_line_conditioner #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic                    clk,
  input  logic                    n_rst,
  i2c_line_conditioner_if.slave   bus
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  // Bit 0 carries SDA, bit 1 carries SCL throughout the line pipeline.
  logic [1:0]    r_sync [SYNC_STAGES];
  logic [1:0]    r_filt;
  logic [CW-1:0] r_cnt [2];
  logic [1:0]    r_prev;
  state_t        r_state;
  state_t        w_state_next;

  logic [1:0] w_raw;
  logic       w_sda;
  logic       w_scl;
  logic       w_sda_prev;
  logic       w_scl_prev;
  logic       w_start;
  logic       w_stop;
  logic       w_timeout;
  logic       w_busy;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 2'b11;
    end else begin
      r_sync[0] <= {bus.SCL_in, bus.SDA_in};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_raw = r_sync[SYNC_STAGES-1];

  // A new level is taken only after it has been seen FILTER_LEN cycles in a row.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_filt <= 2'b11;
      for (int l = 0; l < 2; l++) r_cnt[l] <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (w_raw[l] == r_filt[l]) begin
          r_cnt[l] <= '0;
        end else if (r_cnt[l] == CW'(FILTER_LEN - 1)) begin
          r_filt[l] <= w_raw[l];
          r_cnt[l]  <= '0;
        end else begin
          r_cnt[l] <= r_cnt[l] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_prev <= 2'b11;
    else        r_prev <= r_filt;
  end

  assign w_sda      = r_filt[0];
  assign w_scl      = r_filt[1];
  assign w_sda_prev = r_prev[0];
  assign w_scl_prev = r_prev[1];

  // SCL must be high on both sides of the SDA edge, so simultaneous SDA/SCL moves are ignored.
  assign w_start = ~w_sda &  w_sda_prev & w_scl & w_scl_prev;
  assign w_stop  =  w_sda & ~w_sda_prev & w_scl & w_scl_prev;
  assign w_busy  = (r_state == ST_BUSY);

`ifdef I2C_BUS_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_to_cnt;

  assign w_timeout = w_busy & ~w_scl & (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)                          r_to_cnt <= '0;
    else if (!w_busy || w_scl || w_timeout) r_to_cnt <= '0;
    else                                 r_to_cnt <= r_to_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // START wins over a coincident timeout so a fresh transfer is never dropped.
  always_comb begin
    w_state_next = r_state;
    if (w_start)                  w_state_next = ST_BUSY;
    else if (w_stop || w_timeout) w_state_next = ST_IDLE;
  end

  assign bus.SDA_sync    = w_sda;
  assign bus.SCL_sync    = w_scl;
  assign bus.SCL_rise    =  w_scl & ~w_scl_prev;
  assign bus.SCL_fall    = ~w_scl &  w_scl_prev;
  assign bus.start_found = w_start;
  assign bus.stop_found  = w_stop;
  assign bus.bus_busy    = w_busy;
  assign bus.bus_timeout = w_timeout;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// tb/tb_i2c_line_conditioner.sv - directed bench with event scoreboard for i2c_line_conditioner
module tb_i2c_line_conditioner;

  localparam logic [4:0] EV_RISE  = 5'b00001;
  localparam logic [4:0] EV_FALL  = 5'b00010;
  localparam logic [4:0] EV_START = 5'b00100;
  localparam logic [4:0] EV_STOP  = 5'b01000;
  localparam logic [4:0] EV_TO    = 5'b10000;

  logic clk;
  logic n_rst;
  int   n_tests;
  int   n_fail;
  int   rise_cnt;
  int   fall_cnt;
  logic [4:0] exp_q[$];

  i2c_line_conditioner_if bus ();

  i2c_line_conditioner #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic settle();
    tick(8);
  endtask

  // Every event the DUT emits must match the next expected entry, in order.
  always @(negedge clk) begin
    logic [4:0] ev;
    ev = {bus.bus_timeout, bus.stop_found, bus.start_found, bus.SCL_fall, bus.SCL_rise};
    if (bus.SCL_rise) rise_cnt++;
    if (bus.SCL_fall) fall_cnt++;
    if (ev != 5'b0) begin
      if (exp_q.size() == 0) check("unexpected_event", {27'b0, ev}, 32'h0);
      else                   check("event", {27'b0, ev}, {27'b0, exp_q.pop_front()});
    end
  end

  initial begin
    int k;
    n_tests  = 0;
    n_fail   = 0;
    rise_cnt = 0;
    fall_cnt = 0;
    n_rst      = 1'b0;
    bus.SDA_in = 1'b1;
    bus.SCL_in = 1'b1;
    tick(3);
    check("reset_sda_sync", bus.SDA_sync, 1'b1);
    check("reset_scl_sync", bus.SCL_sync, 1'b1);
    check("reset_busy", bus.bus_busy, 1'b0);
    check("reset_timeout", bus.bus_timeout, 1'b0);
    n_rst = 1'b1;
    tick(3);

    // Latency: the filtered level appears exactly 6 clocks after the pin; with SCL high it is a START.
    bus.SDA_in = 1'b0;
    exp_q.push_back(EV_START);
    tick(5);
    check("latency_sda_still_high", bus.SDA_sync, 1'b1);
    tick(1);
    check("latency_sda_low", bus.SDA_sync, 1'b0);
    check("start_pulse", bus.start_found, 1'b1);
    check("busy_not_yet", bus.bus_busy, 1'b0);
    tick(1);
    check("start_pulse_single", bus.start_found, 1'b0);
    check("busy_after_start", bus.bus_busy, 1'b1);
    bus.SDA_in = 1'b1;
    exp_q.push_back(EV_STOP);
    tick(6);
    check("stop_pulse", bus.stop_found, 1'b1);
    check("busy_during_stop", bus.bus_busy, 1'b1);
    tick(1);
    check("busy_after_stop", bus.bus_busy, 1'b0);
    settle();

    // A 3-cycle SDA glitch is dropped.
    bus.SDA_in = 1'b0;
    tick(3);
    bus.SDA_in = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (bus.SDA_sync !== 1'b1) k++;
    end
    check("glitch_dropped", k, 0);
    check("glitch_no_busy", bus.bus_busy, 1'b0);

    // START, data-bit SDA change under SCL low, repeated START, 9 SCL pulses, STOP.
    bus.SDA_in = 1'b0; exp_q.push_back(EV_START); settle();
    check("t4_busy", bus.bus_busy, 1'b1);
    bus.SCL_in = 1'b0; exp_q.push_back(EV_FALL);  settle();
    bus.SDA_in = 1'b1;                            settle();
    bus.SCL_in = 1'b1; exp_q.push_back(EV_RISE);  settle();
    bus.SDA_in = 1'b0; exp_q.push_back(EV_START); settle();
    check("rstart_busy", bus.bus_busy, 1'b1);
    rise_cnt = 0;
    fall_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      bus.SCL_in = 1'b0; exp_q.push_back(EV_FALL); settle();
      bus.SCL_in = 1'b1; exp_q.push_back(EV_RISE); settle();
    end
    check("scl_rise_count", rise_cnt, 9);
    check("scl_fall_count", fall_cnt, 9);
    check("toggle_busy", bus.bus_busy, 1'b1);
    bus.SDA_in = 1'b1; exp_q.push_back(EV_STOP); settle();
    check("t4_idle", bus.bus_busy, 1'b0);

    // Simultaneous SDA/SCL fall: only SCL_fall. Then STOP while idle keeps busy low.
    bus.SDA_in = 1'b0;
    bus.SCL_in = 1'b0;
    exp_q.push_back(EV_FALL); settle();
    check("simul_no_busy", bus.bus_busy, 1'b0);
    bus.SCL_in = 1'b1; exp_q.push_back(EV_RISE); settle();
    bus.SDA_in = 1'b1; exp_q.push_back(EV_STOP); settle();
    check("idle_stop_busy", bus.bus_busy, 1'b0);

    // Asynchronous reset mid-transfer drops bus_busy at once.
    bus.SDA_in = 1'b0; exp_q.push_back(EV_START); settle();
    bus.SCL_in = 1'b0; exp_q.push_back(EV_FALL);  settle();
    check("pre_reset_busy", bus.bus_busy, 1'b1);
    n_rst = 1'b0;
    #1;
    check("async_reset_busy", bus.bus_busy, 1'b0);
    check("async_reset_scl", bus.SCL_sync, 1'b1);
    bus.SDA_in = 1'b1;
    bus.SCL_in = 1'b1;
    tick(2);
    n_rst = 1'b1;
    settle();

    // SCL held low while busy.
    bus.SDA_in = 1'b0; exp_q.push_back(EV_START); settle();
    bus.SCL_in = 1'b0; exp_q.push_back(EV_FALL);
    tick(6);
    check("to_fall_seen", bus.SCL_fall, 1'b1);
`ifdef I2C_BUS_TIMEOUT_EN
    exp_q.push_back(EV_TO);
    k = 0;
    while (bus.bus_timeout !== 1'b1 && k < 80) begin
      tick(1);
      k++;
    end
    check("timeout_cycle", k, 49);
    check("timeout_busy_still", bus.bus_busy, 1'b1);
    tick(1);
    check("timeout_single", bus.bus_timeout, 1'b0);
    check("timeout_busy_cleared", bus.bus_busy, 1'b0);
    bus.SCL_in = 1'b1; exp_q.push_back(EV_RISE); settle();
    bus.SDA_in = 1'b1; exp_q.push_back(EV_STOP); settle();
`else
    k = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (bus.bus_timeout !== 1'b0) k++;
    end
    check("no_timeout_pulse", k, 0);
    check("no_timeout_busy", bus.bus_busy, 1'b1);
    bus.SCL_in = 1'b1; exp_q.push_back(EV_RISE); settle();
    bus.SDA_in = 1'b1; exp_q.push_back(EV_STOP); settle();
`endif
    check("final_idle", bus.bus_busy, 1'b0);
    check("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
